// File: rtl/memory_responder_if.sv
// Purpose: request/response bundle between a fetch/memory-stage requester and memory_responder.
// Latency: none (wires only).
// Backpressure: busy from the responder stalls the requester; wr_ready paces write data.
//   enable/rw/addr/access_size : request strobe, direction (1=read), byte address, burst size
//   data_in                    : write data, one word per cycle while wr_ready=1
//   data_out/data_valid        : read data and its qualifier
//   wr_ready/busy/error        : write-consume strobe, request in progress, out-of-range flag
interface memory_responder_if;
    logic        enable;
    logic        rw;
    logic [31:0] addr;
    logic [1:0]  access_size;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        data_valid;
    logic        wr_ready;
    logic        busy;
    logic        error;

    modport master (
        output enable, rw, addr, access_size, data_in,
        input  data_out, data_valid, wr_ready, busy, error
    );

    modport slave (
        input  enable, rw, addr, access_size, data_in,
        output data_out, data_valid, wr_ready, busy, error
    );
endinterface

// File: rtl/memory_responder.sv
// Purpose: word-organised RAM at BASE_ADDR serving single and burst (1/4/8/16) reads and writes.
// Latency: first read word valid the cycle after the accept edge, then one word per cycle.
// Backpressure: busy=1 for the whole burst; requests are only sampled while busy=0.
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   bus (slave)    : request, write data, read data and status (see memory_responder_if)
module memory_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h8002_0000,
    parameter int          DEPTH_WORDS = 1024
) (
    input  logic               clock,
    input  logic               reset_n,
    memory_responder_if.slave  bus
);
    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];
    localparam logic [30:0] DEPTH_W   = 31'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    // One extra bit above the 30-bit word offset so that incrementing past
    // the top of the address space stays out of range instead of wrapping
    // back into the RAM.
    logic [30:0] word_addr_q, word_addr_d;
    logic [3:0]  remaining_q, remaining_d;
    logic        error_q, error_d;
    logic [31:0] last_q, last_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic [29:0] start_word;
    logic        in_range;
    logic [31:0] rd_word;
    logic        mem_we;
    logic [3:0]  len_m1;

    // Addresses below BASE_ADDR underflow to a huge offset and fail the range check.
    assign start_word = bus.addr[31:2] - BASE_WORD;
    assign in_range   = (word_addr_q < DEPTH_W);
    assign rd_word    = in_range ? mem[word_addr_q[AW-1:0]] : '0;
    assign mem_we     = (state_q == WRITE) && in_range;

    always_comb begin
        len_m1 = 4'd0;
        case (bus.access_size)
            2'b00:   len_m1 = 4'd0;
            2'b01:   len_m1 = 4'd3;
            2'b10:   len_m1 = 4'd7;
            default: len_m1 = 4'd15;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        word_addr_d = word_addr_q;
        remaining_d = remaining_q;
        error_d     = error_q;
        last_d      = last_q;
        case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    word_addr_d = {1'b0, start_word};
                    remaining_d = len_m1;
                    error_d     = 1'b0;
                    state_d     = bus.rw ? READ : WRITE;
                end
            end
            READ, WRITE: begin
                if (state_q == READ) begin
                    last_d = rd_word;
                end
                if (!in_range) begin
                    error_d = 1'b1;
                end
                word_addr_d = word_addr_q + 31'd1;
                remaining_d = remaining_q - 4'd1;
                if (remaining_q == 4'd0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            word_addr_q <= '0;
            remaining_q <= '0;
            error_q     <= 1'b0;
            last_q      <= '0;
        end else begin
            state_q     <= state_d;
            word_addr_q <= word_addr_d;
            remaining_q <= remaining_d;
            error_q     <= error_d;
            last_q      <= last_d;
        end
    end

    // RAM contents survive reset; out-of-range write beats are simply dropped.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[word_addr_q[AW-1:0]] <= bus.data_in;
        end
    end

    // During a read the current word is driven straight from the RAM; between
    // bursts the last word read is held.
    assign bus.data_valid = (state_q == READ);
    assign bus.wr_ready   = (state_q == WRITE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.error      = error_q;
    assign bus.data_out   = (state_q == READ) ? rd_word : last_q;
endmodule
